// File: rtl/cmn_age_matrix_sel.sv
// cmn_age_matrix_sel: age-matrix oldest selector (in: clk rst alloc_vld alloc_idx dealloc req; out: gnt gnt_vld gnt_idx oldest entry_vld cnt full err)
module cmn_age_matrix_sel #(
  parameter int DEPTH = 8,
  parameter int ALLOC_PORTS = 2,
  parameter int IDX_W = $clog2(DEPTH),
  parameter bit SEL_REG = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ALLOC_PORTS-1:0]       alloc_vld,
  input  logic [ALLOC_PORTS*IDX_W-1:0] alloc_idx,
  input  logic [DEPTH-1:0]             dealloc,
  input  logic [DEPTH-1:0]             req,
  output logic [DEPTH-1:0]             gnt,
  output logic                         gnt_vld,
  output logic [IDX_W-1:0]             gnt_idx,
  output logic [DEPTH-1:0]             oldest,
  output logic [DEPTH-1:0]             entry_vld,
  output logic [IDX_W:0]               cnt,
  output logic                         full,
  output logic                         err
);
  logic [DEPTH-1:0] up_q [DEPTH];
  logic [DEPTH-1:0] up_d [DEPTH];
  logic [DEPTH-1:0] older [DEPTH];
  logic [DEPTH-1:0] al, vld_d, elig, gnt_c, old_c;
  logic [IDX_W-1:0] ix, gidx_c;
  logic [IDX_W:0] cnt_d;
  logic err_d;
  int pos [DEPTH];
  assign full = cnt == (IDX_W+1)'(DEPTH);
  assign oldest = old_c;
  assign elig = req & entry_vld;
  always_comb begin
    al = '0;
    ix = '0;
    err_d = err;
    cnt_d = '0;
    for (int n = 0; n < DEPTH; n++) pos[n] = 0;
    for (int p = 0; p < ALLOC_PORTS; p++) begin
      ix = alloc_idx[p*IDX_W +: IDX_W];
      if (alloc_vld[p] && 32'(ix) >= DEPTH) err_d = 1'b1;
      else if (alloc_vld[p]) begin
        err_d = err_d | al[ix];
        al[ix] = 1'b1;
        pos[ix] = p;
      end
    end
    err_d = err_d | (|(al & entry_vld & ~dealloc)) | (full & (|al) & ~(|dealloc));
    vld_d = (entry_vld & ~dealloc) | al;
    for (int n = 0; n < DEPTH; n++) cnt_d = cnt_d + (IDX_W+1)'(vld_d[n]);
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        up_d[i][j] = (i >= j) ? 1'b0 :
                     (al[i] & al[j]) ? (pos[i] < pos[j]) :
                     al[j] ? 1'b1 : al[i] ? 1'b0 : up_q[i][j];
  end
  // older[i][j]: entry j is older than entry i, rebuilt from the stored upper triangle
  always_comb begin
    gnt_c = '0;
    old_c = '0;
    gidx_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      older[i] = '0;
      for (int j = 0; j < DEPTH; j++)
        older[i][j] = (j < i) ? up_q[j][i] : (j > i) ? ~up_q[i][j] : 1'b0;
      gnt_c[i] = elig[i] & ~(|(elig & older[i]));
      old_c[i] = entry_vld[i] & ~(|(entry_vld & older[i]));
      gidx_c = gidx_c | (gnt_c[i] ? IDX_W'(i) : '0);
    end
  end
  always_ff @(posedge clk) begin
    entry_vld <= rst ? '0 : vld_d;
    cnt <= rst ? '0 : cnt_d;
    err <= rst ? 1'b0 : err_d;
    for (int i = 0; i < DEPTH; i++) up_q[i] <= rst ? '0 : up_d[i];
  end
  if (SEL_REG) begin : g_reg
    always_ff @(posedge clk) begin
      gnt <= rst ? '0 : gnt_c;
      gnt_vld <= rst ? 1'b0 : |gnt_c;
      gnt_idx <= rst ? '0 : gidx_c;
    end
  end else begin : g_comb
    assign gnt = gnt_c;
    assign gnt_vld = |gnt_c;
    assign gnt_idx = gidx_c;
  end
endmodule

// File: tb/tb_cmn_age_matrix_sel.sv
// tb_cmn_age_matrix_sel: timestamp-model scoreboard bench for both selection modes
module tb_cmn_age_matrix_sel;
  localparam int D = 8, AP = 2, IW = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic [AP-1:0] alloc_vld = '0;
  logic [AP*IW-1:0] alloc_idx = '0;
  logic [D-1:0] dealloc = '0, req = '0;
  logic [D-1:0] gnt0, oldest0, vld0, gnt1, oldest1, vld1;
  logic gv0, full0, err0, gv1, full1, err1;
  logic [IW-1:0] gi0, gi1;
  logic [IW:0] cnt0, cnt1;
  always #5 clk = ~clk;
  cmn_age_matrix_sel #(.DEPTH(D), .ALLOC_PORTS(AP), .SEL_REG(1'b0)) u0 (
    .clk(clk), .rst(rst), .alloc_vld(alloc_vld), .alloc_idx(alloc_idx), .dealloc(dealloc), .req(req),
    .gnt(gnt0), .gnt_vld(gv0), .gnt_idx(gi0), .oldest(oldest0), .entry_vld(vld0), .cnt(cnt0),
    .full(full0), .err(err0));
  cmn_age_matrix_sel #(.DEPTH(D), .ALLOC_PORTS(AP), .SEL_REG(1'b1)) u1 (
    .clk(clk), .rst(rst), .alloc_vld(alloc_vld), .alloc_idx(alloc_idx), .dealloc(dealloc), .req(req),
    .gnt(gnt1), .gnt_vld(gv1), .gnt_idx(gi1), .oldest(oldest1), .entry_vld(vld1), .cnt(cnt1),
    .full(full1), .err(err1));
  typedef struct packed {
    logic [D-1:0] gnt, oldest, vld, rg;
    logic [IW-1:0] gi, rgi;
    logic gv, rgv, full, err;
    logic [IW:0] cnt;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [D-1:0] mv = '0, rg = '0;
  longint ts [D];
  longint tick = 0;
  bit merr = 0;
  function automatic logic [D-1:0] pick(input logic [D-1:0] m);
    logic [D-1:0] r = '0;
    longint best = 0;
    bit f = 0;
    for (int i = 0; i < D; i++)
      if (m[i] && (!f || ts[i] < best)) begin
        best = ts[i];
        f = 1;
        r = '0;
        r[i] = 1'b1;
      end
    return r;
  endfunction
  function automatic logic [IW-1:0] enc(input logic [D-1:0] m);
    logic [IW-1:0] r = '0;
    for (int i = 0; i < D; i++) if (m[i]) r = IW'(i);
    return r;
  endfunction
  function automatic int pop(input logic [D-1:0] m);
    int c = 0;
    for (int i = 0; i < D; i++) c += int'(m[i]);
    return c;
  endfunction
  task automatic chk(input string nm, input logic [D-1:0] act, input logic [D-1:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req_v, $time);
    end
  endtask
  // apply the edge to the model: allocations are stamped by cycle then port, smallest stamp is oldest
  task automatic model_edge();
    logic [D-1:0] g, al;
    int ix;
    g = pick(mv & req);
    al = '0;
    if (rst) begin
      mv = '0;
      merr = 0;
      rg = '0;
    end else begin
      rg = g;
      for (int p = 0; p < AP; p++) begin
        ix = int'(alloc_idx[p*IW +: IW]);
        if (alloc_vld[p] && ix >= D) merr = 1;
        else if (alloc_vld[p]) begin
          if (al[ix] || (mv[ix] && !dealloc[ix])) merr = 1;
          al[ix] = 1'b1;
          ts[ix] = tick * AP + p;
        end
      end
      if (pop(mv) == D && al != 0 && dealloc == 0) merr = 1;
      mv = (mv & ~dealloc) | al;
    end
    tick++;
  endtask
  task automatic step(input logic r, input logic [AP-1:0] av, input logic [AP*IW-1:0] ai,
                      input logic [D-1:0] dl, input logic [D-1:0] rq);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    rst = r;
    alloc_vld = av;
    alloc_idx = ai;
    dealloc = dl;
    req = rq;
    e.gnt = pick(mv & req);
    e.gi = enc(e.gnt);
    e.gv = |e.gnt;
    e.oldest = pick(mv);
    e.vld = mv;
    e.cnt = (IW+1)'(pop(mv));
    e.full = pop(mv) == D;
    e.err = merr;
    e.rg = rg;
    e.rgi = enc(rg);
    e.rgv = |rg;
    q.push_back(e);
  endtask
  always @(negedge clk) if (q.size() > 0) begin
    exp_t e;
    e = q.pop_front();
    chk("gnt", gnt0, e.gnt);
    chk("gnt_vld", D'(gv0), D'(e.gv));
    chk("gnt_idx", D'(gi0), D'(e.gi));
    chk("oldest", oldest0, e.oldest);
    chk("entry_vld", vld0, e.vld);
    chk("cnt", D'(cnt0), D'(e.cnt));
    chk("full", D'(full0), D'(e.full));
    chk("err", D'(err0), D'(e.err));
    chk("reg_gnt", gnt1, e.rg);
    chk("reg_gnt_vld", D'(gv1), D'(e.rgv));
    chk("reg_gnt_idx", D'(gi1), D'(e.rgi));
    chk("reg_oldest", oldest1, e.oldest);
    chk("reg_err", D'(err1), D'(e.err));
  end
  initial begin
    step(1, 0, 0, 0, 0);
    step(0, 2'b11, {3'd5, 3'd3}, 0, 0);
    step(0, 2'b01, {3'd0, 3'd0}, 0, 0);
    step(0, 0, 0, 0, 8'hFF);
    #4;
    chk("spot_gnt", gnt0, 8'h08);
    chk("spot_cnt", D'(cnt0), 8'd3);
    step(0, 0, 0, 8'h08, 8'hFF);
    step(0, 0, 0, 0, 8'hFF);
    #4;
    chk("spot_gnt_after_dealloc", gnt0, 8'h20);
    step(0, 0, 0, 0, 8'h01);
    step(1, 0, 0, 0, 0);
    step(0, 2'b11, {3'd6, 3'd7}, 0, 0);
    step(0, 2'b11, {3'd4, 3'd5}, 0, 0);
    step(0, 2'b11, {3'd2, 3'd3}, 0, 0);
    step(0, 2'b11, {3'd0, 3'd1}, 0, 0);
    step(0, 0, 0, 0, 8'hFF);
    #4;
    chk("spot_oldest_full", oldest0, 8'h80);
    chk("spot_full", D'(full0), 8'd1);
    step(0, 2'b01, {3'd0, 3'd2}, 8'h04, 8'h04);
    step(0, 0, 0, 0, 8'h04);
    step(0, 2'b01, {3'd0, 3'd4}, 0, 0);
    step(0, 0, 0, 0, 8'hFF);
    #4;
    chk("spot_err", D'(err0), 8'd1);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 2'b11, {3'd6, 3'd6}, 0, 0);
    step(0, 0, 0, 0, 8'hFF);
    step(1, 0, 0, 0, 0);
    step(0, 2'b01, {3'd0, 3'd1}, 0, 0);
    step(0, 2'b01, {3'd0, 3'd2}, 0, 0);
    step(0, 0, 0, 0, 8'h06);
    step(0, 0, 0, 0, 8'h00);
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 39) == 0, AP'($urandom), (AP*IW)'($urandom),
           D'($urandom & $urandom & $urandom), D'($urandom));
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", D'(q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
